// File: rtl/instr_sequencer_if.sv
// Program-memory, flag and datapath-control bundle between the instruction
// sequencer (master) and the memory/accumulator datapath side (slave).
interface instr_sequencer_if #(
   parameter int unsigned ADDR_W = 8
);
   localparam int unsigned INSTR_W = ADDR_W + 4;

   logic               run;
   logic [INSTR_W-1:0] prog_data;
   logic               C;
   logic               Z;
   logic [ADDR_W-1:0]  prog_addr;
   logic               buffIn;
   logic               buffOut;
   logic               enAccu;
   logic [2:0]         F;
   logic [3:0]         busInput;
   logic               flag_c;
   logic               flag_z;
   logic               halted;

   modport master (
      input  run, prog_data, C, Z,
      output prog_addr, buffIn, buffOut, enAccu, F, busInput,
             flag_c, flag_z, halted
   );

   modport slave (
      output run, prog_data, C, Z,
      input  prog_addr, buffIn, buffOut, enAccu, F, busInput,
             flag_c, flag_z, halted
   );
endinterface

// File: rtl/instr_sequencer.sv
// Two-cycle FETCH/EXEC control stage for the 4-bit accumulator datapath:
// fetches instruction words, decodes datapath controls and resolves jumps.
module instr_sequencer #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   instr_sequencer_if.master bus
);
   localparam int unsigned INSTR_W = ADDR_W + 4;

   localparam logic [3:0] OP_OUT  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_JC   = 4'hA;
   localparam logic [3:0] OP_JNC  = 4'hB;
   localparam logic [3:0] OP_JZ   = 4'hC;
   localparam logic [3:0] OP_JNZ  = 4'hD;
   localparam logic [3:0] OP_NOP  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  w_pc_nxt;
   logic [INSTR_W-1:0] r_ir;
   logic [INSTR_W-1:0] w_ir_nxt;
   logic               r_flag_c;
   logic               w_flag_c_nxt;
   logic               r_flag_z;
   logic               w_flag_z_nxt;
   logic               r_halted;
   logic               w_halted_nxt;

   logic               w_buff_in;
   logic               w_buff_out;
   logic               w_en_accu;
   logic [2:0]         w_f;
   logic [3:0]         w_bus_input;
   logic               w_take;

   logic [3:0]         w_op;
   logic [ADDR_W-1:0]  w_arg;

   assign w_op  = r_ir[INSTR_W-1:ADDR_W];
   assign w_arg = r_ir[ADDR_W-1:0];

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Program counter, instruction register, flags and halt indication
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc     <= '0;
         r_ir     <= '0;
         r_flag_c <= 1'b0;
         r_flag_z <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         r_pc     <= w_pc_nxt;
         r_ir     <= w_ir_nxt;
         r_flag_c <= w_flag_c_nxt;
         r_flag_z <= w_flag_z_nxt;
         r_halted <= w_halted_nxt;
      end
   end

   // Next-state and control decode; controls are live only during EXEC
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_ir_nxt     = r_ir;
      w_flag_c_nxt = r_flag_c;
      w_flag_z_nxt = r_flag_z;
      w_halted_nxt = r_halted;
      w_buff_in    = 1'b0;
      w_buff_out   = 1'b0;
      w_en_accu    = 1'b0;
      w_f          = 3'b000;
      w_bus_input  = 4'b0000;
      w_take       = 1'b0;

      unique case (r_state)
         ST_FETCH: begin
            if (bus.run) begin
               w_ir_nxt    = bus.prog_data;
               w_pc_nxt    = r_pc + ADDR_W'(1);
               w_state_nxt = ST_EXEC;
            end
         end

         ST_EXEC: begin
            w_state_nxt = ST_FETCH;
            if (!w_op[3]) begin
               // ALU-immediate: only the low nibble of arg reaches the datapath
               w_f          = w_op[2:0];
               w_bus_input  = w_arg[3:0];
               w_buff_in    = 1'b1;
               w_en_accu    = 1'b1;
               w_flag_c_nxt = bus.C;
               w_flag_z_nxt = bus.Z;
            end else begin
               case (w_op)
                  OP_OUT:  w_buff_out = 1'b1;
                  OP_JMP:  w_take     = 1'b1;
                  OP_JC:   w_take     = r_flag_c;
                  OP_JNC:  w_take     = !r_flag_c;
                  OP_JZ:   w_take     = r_flag_z;
                  OP_JNZ:  w_take     = !r_flag_z;
                  OP_NOP:  w_take     = 1'b0;
                  OP_HALT: begin
                     w_state_nxt  = ST_HALT;
                     w_halted_nxt = 1'b1;
                  end
                  default: w_take = 1'b0;
               endcase
            end
            if (w_take) begin
               w_pc_nxt = w_arg;
            end
         end

         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end

         default: begin
            w_state_nxt = ST_FETCH;
         end
      endcase
   end

   assign bus.prog_addr = r_pc;
   assign bus.buffIn    = w_buff_in;
   assign bus.buffOut   = w_buff_out;
   assign bus.enAccu    = w_en_accu;
   assign bus.F         = w_f;
   assign bus.busInput  = w_bus_input;
   assign bus.flag_c    = r_flag_c;
   assign bus.flag_z    = r_flag_z;
   assign bus.halted    = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Instruction-level reference checks for instr_sequencer: directed programs
// followed by random programs with random stalls and random C/Z flags.
module tb_instr_sequencer;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned INSTR_W = ADDR_W + 4;
   localparam int unsigned DEPTH   = 2 ** ADDR_W;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   instr_sequencer #(.ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [INSTR_W-1:0] mem [DEPTH];
   assign bus.prog_data = mem[bus.prog_addr];

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Architectural model state
   logic [ADDR_W-1:0] m_pc;
   logic              m_c;
   logic              m_z;
   logic              m_halted;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_arch(input string tag);
      check({tag, ".pc"},     32'(bus.prog_addr), 32'(m_pc));
      check({tag, ".flag_c"}, 32'(bus.flag_c),    32'(m_c));
      check({tag, ".flag_z"}, 32'(bus.flag_z),    32'(m_z));
      check({tag, ".halted"}, 32'(bus.halted),    32'(m_halted));
   endtask

   task automatic check_ctrl(input string tag, input logic bi, input logic bo,
                             input logic ea, input logic [2:0] f, input logic [3:0] bin);
      check({tag, ".ctrl"},
            32'({bus.buffIn, bus.buffOut, bus.enAccu, bus.F, bus.busInput}),
            32'({bi, bo, ea, f, bin}));
   endtask

   task automatic model_reset();
      m_pc     = '0;
      m_c      = 1'b0;
      m_z      = 1'b0;
      m_halted = 1'b0;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      bus.run  = 1'b0;
      bus.C    = 1'($urandom);
      bus.Z    = 1'($urandom);
      model_reset();
      @(negedge clk);
      check_ctrl("rst", 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
      check_arch("rst");
      tick();
      reset = 1'b1;
   endtask

   // One instruction: optional stall cycles, FETCH cycle, EXEC cycle
   task automatic run_instr(input logic c_in, input logic z_in, input int stalls);
      logic [INSTR_W-1:0] instr;
      logic [3:0]         op;
      logic [ADDR_W-1:0]  arg;
      for (int i = 0; i < stalls; i++) begin
         bus.run = 1'b0;
         bus.C   = 1'($urandom);
         bus.Z   = 1'($urandom);
         @(negedge clk);
         check_ctrl("stall", 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
         check_arch("stall");
         tick();
      end
      bus.run = 1'b1;
      bus.C   = 1'($urandom);
      bus.Z   = 1'($urandom);
      @(negedge clk);
      check_ctrl("fetch", 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
      check_arch("fetch");
      instr = mem[m_pc];
      m_pc  = m_pc + 1'b1;
      tick();

      bus.run = 1'($urandom);
      bus.C   = c_in;
      bus.Z   = z_in;
      op  = instr[INSTR_W-1:ADDR_W];
      arg = instr[ADDR_W-1:0];
      @(negedge clk);
      if (op < 4'd8)       check_ctrl("exec_alu", 1'b1, 1'b0, 1'b1, op[2:0], arg[3:0]);
      else if (op == 4'd8) check_ctrl("exec_out", 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
      else                 check_ctrl("exec_oth", 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
      check_arch("exec");

      if (op < 4'd8) begin
         m_c = c_in;
         m_z = z_in;
      end
      case (op)
         4'h9: m_pc = arg;
         4'hA: if (m_c)  m_pc = arg;
         4'hB: if (!m_c) m_pc = arg;
         4'hC: if (m_z)  m_pc = arg;
         4'hD: if (!m_z) m_pc = arg;
         4'hF: m_halted = 1'b1;
         default: ;
      endcase
      tick();
   endtask

   task automatic halt_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         bus.run = 1'($urandom);
         bus.C   = 1'($urandom);
         bus.Z   = 1'($urandom);
         @(negedge clk);
         check_ctrl("halt", 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
         check_arch("halt");
         tick();
      end
   endtask

   task automatic fill_nop();
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = 12'hE00;
   endtask

   initial begin
      reset   = 1'b0;
      bus.run = 1'b0;
      bus.C   = 1'b0;
      bus.Z   = 1'b0;
      fill_nop();
      model_reset();
      tick();
      do_reset();

      // ALU-immediate pair then JC taken
      mem[0] = 12'h20A;
      mem[1] = 12'h301;
      mem[2] = 12'hA10;
      run_instr(1'b0, 1'b1, 0);
      run_instr(1'b1, 1'b0, 0);
      run_instr(1'b0, 1'b0, 0);
      @(negedge clk);
      check("jc_taken_pc", 32'(bus.prog_addr), 32'h10);
      tick();

      // Same program, JC not taken
      do_reset();
      run_instr(1'b0, 1'b0, 0);
      run_instr(1'b0, 1'b1, 0);
      run_instr(1'b1, 1'b1, 0);
      @(negedge clk);
      check("jc_not_taken_pc", 32'(bus.prog_addr), 32'h3);
      check("jc_flag_c_kept", 32'(bus.flag_c), 32'h0);
      tick();

      // OUT preserves flags; JZ taken; stall; JMP to 0xFF; NOP wraps pc
      do_reset();
      mem[0] = 12'h402;
      mem[1] = 12'h800;
      mem[2] = 12'hC07;
      mem[7] = 12'h9FF;
      mem[8'hFF] = 12'hE00;
      run_instr(1'b0, 1'b1, 0);
      run_instr(1'b1, 1'b0, 0);
      run_instr(1'b1, 1'b0, 0);
      run_instr(1'b0, 1'b0, 5);
      run_instr(1'b0, 1'b0, 0);
      @(negedge clk);
      check("wrap_pc", 32'(bus.prog_addr), 32'h0);
      tick();

      // HALT at address 1
      fill_nop();
      do_reset();
      mem[1] = 12'hF00;
      run_instr(1'b1, 1'b1, 0);
      run_instr(1'b1, 1'b1, 1);
      halt_cycles(6);
      reset = 1'b0;
      #1;
      check("halt_rst_halted", 32'(bus.halted), 32'h0);
      check("halt_rst_pc", 32'(bus.prog_addr), 32'h0);
      tick();
      do_reset();

      // Asynchronous reset in the middle of an ALU EXEC
      fill_nop();
      mem[0] = 12'h2FF;
      mem[1] = 12'h50A;
      run_instr(1'b1, 1'b1, 0);
      bus.run = 1'b1;
      tick();
      @(negedge clk);
      check("pre_rst_enaccu", 32'(bus.enAccu), 32'h1);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_pc", 32'(bus.prog_addr), 32'h0);
      check("async_rst_enaccu", 32'(bus.enAccu), 32'h0);
      check("async_rst_f", 32'(bus.F), 32'h0);
      check("async_rst_flags", 32'({bus.flag_c, bus.flag_z}), 32'h0);
      tick();
      do_reset();

      // Random programs
      for (int p = 0; p < 20; p++) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] = INSTR_W'($urandom);
         do_reset();
         for (int k = 0; k < 80 && !m_halted; k++) begin
            run_instr(1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
         end
         if (m_halted) halt_cycles(3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Control stage directly upstream of the 4-bit accumulator datapath.
- Fetches 12-bit instruction words from an external program memory.
- Drives the datapath controls: buffIn, buffOut, enAccu, F, busInput.
- Latches the datapath's C/Z flags and uses them for conditional jumps.
- Two-cycle FETCH/EXEC machine with run-gating and a HALT state.

Parameters:
- ADDR_W, 8: program-counter and prog_addr width. Instruction word width is 4+ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  fetch enable. 0 holds the sequencer in FETCH.
- prog_data  in  4+ADDR_W  instruction at prog_addr, combinational from memory. op=[ADDR_W+3:ADDR_W], arg=[ADDR_W-1:0].
- C  in  1  datapath carry flag, valid in the cycle enAccu=1.
- Z  in  1  datapath zero flag, valid in the cycle enAccu=1.
- prog_addr  out  ADDR_W  program counter.
- buffIn  out  1  datapath input-buffer enable.
- buffOut  out  1  datapath output-buffer enable.
- enAccu  out  1  accumulator load enable.
- F  out  3  ALU function select.
- busInput  out  4  immediate operand to datapath.
- flag_c  out  1  latched carry.
- flag_z  out  1  latched zero.
- halted  out  1  high in HALT.

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, pc=0, ir=0, flag_c=0, flag_z=0, halted=0. All datapath controls 0. Takes effect mid-instruction with no completion.
- Control outputs are decoded from state and ir only, with no extra register stage. In FETCH and HALT all of buffIn, buffOut, enAccu, F, busInput are 0.
- FETCH with run=0: hold; pc, ir and flags unchanged.
- FETCH with run=1: ir<=prog_data, pc<=pc+1 (mod 2^ADDR_W), next state EXEC.
- EXEC: lasts exactly one cycle, then returns to FETCH. Throughput is 1 instruction per 2 cycles; run is not sampled in EXEC.
- Opcodes, by ir op field:
  - 0000-0111 ALU-immediate: F=op[2:0], busInput=arg[3:0], buffIn=1, enAccu=1. At the end of the cycle flag_c<=C, flag_z<=Z. arg[ADDR_W-1:4] is ignored.
  - 1000 OUT: buffOut=1, enAccu=0; flags unchanged.
  - 1001 JMP: pc<=arg.
  - 1010 JC: pc<=arg if flag_c=1.
  - 1011 JNC: pc<=arg if flag_c=0.
  - 1100 JZ: pc<=arg if flag_z=1.
  - 1101 JNZ: pc<=arg if flag_z=0.
  - 1110 NOP: no controls asserted.
  - 1111 HALT: next state HALT.
- Jumps:
  - A not-taken jump leaves pc at the incremented value.
  - A jump to its own address is legal and yields a tight loop.
  - Conditional jumps test the registered flags, never the live C/Z.
- pc wrap: 2^ADDR_W-1 increments to 0.
- HALT: pc frozen; halted=1. Exit only through reset.
- Flags: updated only by ALU-immediate EXEC cycles. OUT, jumps, NOP and HALT preserve them.

Test Plan:
- Reset: reset=0 in the middle of an EXEC with enAccu=1 -> prog_addr=0, enAccu=0, F=000, flag_c=0, flag_z=0 asynchronously, before the next clock edge.
- ALU-immediate: run=1, prog[0]=0x20A, prog[1]=0x301 ->
  - Cycle 2: F=010, busInput=1010, buffIn=1, enAccu=1, prog_addr=1.
  - Cycle 4: F=011, busInput=0001.
  - Cycles 1 and 3: all controls 0.
- Conditional jump taken/not taken, prog[2]=0xA10 (JC 0x10):
  - C=1 during the preceding ALU EXEC -> prog_addr=0x10 after the JC EXEC.
  - C=0 -> prog_addr=3. flag_c is unchanged by the JC itself.
- OUT and flag retention: prog=0x402 (C=0,Z=1), 0x800, 0xC07 ->
  - OUT EXEC: buffOut=1, enAccu=0.
  - JZ taken to 7: Z latched before OUT is preserved.
- run stall and wrap:
  - run=0 for 5 cycles in FETCH -> prog_addr constant, controls 0.
  - pc=0xFF executing NOP (0xE00) -> prog_addr=0x00.
- HALT: prog[k]=0xF00 -> halted=1 from the cycle after its EXEC onward, prog_addr=k+1 frozen, controls 0 regardless of run. reset=0 -> halted=0, prog_addr=0.
